instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
//
// PURPOSE
//  Instruction source for the single-cycle decode/datapath top: holds a word-addressed
//  instruction memory and a program counter, issues one 32-bit Instr at a time over a
//  valid/ready handshake, and takes branches using the PCSrc bit fed back from control.
//  Sits upstream of the decoder's Instr input; the memory is loaded by the bench while the
//  block is IDLE or HALT.
//
// PARAMETERS
//  IMEM_DEPTH  64            instruction memory depth in 32-bit words (power of 2)
//  PC_RESET    32'h0000_0000 byte address of first instruction after start
//  HALT_WORD   32'hFFFF_FFFF instruction encoding that stops fetch
//
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  load_en      in   1   write load_data to imem[load_addr] (IDLE/HALT only)
//  load_addr    in   AW  word address, AW = $clog2(IMEM_DEPTH)
//  load_data    in   32  instruction word to store
//  start        in   1   begin execution at PC_RESET (IDLE/HALT only)
//  instr_ready  in   1   consumer accepts Instr this cycle
//  PCSrc        in   1   branch taken for the instruction being accepted
//  instr_valid  out  1   Instr holds a valid instruction
//  Instr        out  32  instruction to decoder
//  pc           out  32  byte address of Instr
//  halted       out  1   HALT state
//  pc_err       out  1   sticky: fetch stopped on out-of-range PC
//
// BEHAVIOUR
//  - Reset: state=IDLE, pc=PC_RESET, Instr=0, instr_valid=0, halted=0, pc_err=0.
//    imem contents NOT cleared. Reset mid-operation aborts the in-flight Instr.
//  - States: IDLE, FETCH, ISSUE, HALT.
//    IDLE : start -> FETCH, pc<=PC_RESET, pc_err<=0.
//    FETCH: Instr<=imem[pc[AW+1:2]] (registered read) -> ISSUE. Always 1 cycle.
//    ISSUE: instr_valid=1; Instr and pc held stable until instr_valid&&instr_ready.
//           On handshake: Instr==HALT_WORD -> HALT, pc unchanged, PCSrc ignored.
//           else npc = PCSrc ? pc+4+({{14{Instr[15]}},Instr[15:0],2'b00}) : pc+4
//           (32-bit, wraps modulo 2^32). npc[31:2] >= IMEM_DEPTH -> HALT, pc_err<=1,
//           pc<=npc. Otherwise pc<=npc -> FETCH.
//    HALT : halted=1, instr_valid=0; start -> FETCH at PC_RESET, clears pc_err.
//  - Latency: start to first instr_valid = 2 cycles; handshake to next instr_valid = 2.
//  - instr_valid low in IDLE, FETCH, HALT; Instr retains last value when not valid.
//  - load_en honoured only in IDLE/HALT; ignored (no write) in FETCH/ISSUE.
//    load_en and start same cycle: write happens, then FETCH reads the written data
//    next cycle (write-before-read ordering guaranteed).
//  - start while in FETCH/ISSUE ignored.
//  - PC misaligned (pc[1:0]!=0) impossible: PC_RESET must be word aligned; imm is <<2.
//  - PCSrc sampled only in the handshake cycle; its value at other times is don't-care.
//
// TESTING
//  1 Reset/idle: reset 2 cycles -> instr_valid=0, pc=0, halted=0; start w/o load reads imem[0].
//  2 Straight line: load 0x20010005,0x20020007,HALT at 0..2, start, ready=1 -> Instr sequence
//    with pc 0,4,8, valid every 2nd cycle, halted=1 after 3rd handshake, pc stays 8.
//  3 Backpressure: ready=0 for 5 cycles in ISSUE -> Instr/pc/instr_valid stable; accept once.
//  4 Branch: word at pc=4 has imm=0x0003, PCSrc=1 at handshake -> next pc=0x14; imm=0xFFFE ->
//    next pc=0x0 (backward); PCSrc=0 -> pc+4.
//  5 Out of range: IMEM_DEPTH=64, branch to pc=0x100 -> HALT, pc_err=1, pc=0x100; start clears.
//  6 Reset mid-ISSUE and load_en during ISSUE -> back to IDLE; ignored load leaves imem unchanged.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bus of the instruction source: memory load port, run control,
// and the Instr valid/ready handshake towards the decoder.
interface instr_fetch_if #(
  parameter int IMEM_DEPTH = 64
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          start;
  logic          instr_ready;
  logic          PCSrc;
  logic          instr_valid;
  logic [31:0]   Instr;
  logic [31:0]   pc;
  logic          halted;
  logic          pc_err;

  modport slave (
    input  load_en, load_addr, load_data, start, instr_ready, PCSrc,
    output instr_valid, Instr, pc, halted, pc_err
  );

  modport master (
    output load_en, load_addr, load_data, start, instr_ready, PCSrc,
    input  instr_valid, Instr, pc, halted, pc_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction source: word-addressed imem plus PC, issuing one Instr at a time
// over valid/ready and following taken branches signalled by PCSrc.
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.slave  bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic        r_pc_err;
  logic        w_pc_err_nxt;
  logic        w_fetch;
  logic        w_load_ok;
  logic        w_handshake;
  logic [31:0] w_imm_ext;
  logic [31:0] w_npc;
  logic        w_oor;

  logic [31:0] r_imem [IMEM_DEPTH];

  assign w_load_ok   = (r_state == IDLE) || (r_state == HALT);
  assign w_handshake = (r_state == ISSUE) && bus.instr_ready;

  // Branch offset is a signed word displacement relative to pc+4.
  assign w_imm_ext = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_npc     = r_pc + 32'd4 + (bus.PCSrc ? w_imm_ext : 32'd0);
  assign w_oor     = |w_npc[31:AW+2];

  // Memory contents survive reset so a program can be reloaded-free restarted.
  always_ff @(posedge clk) begin
    if (bus.load_en && w_load_ok) begin
      r_imem[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= PC_RESET;
      r_instr  <= 32'd0;
      r_pc_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_err <= w_pc_err_nxt;
      if (w_fetch) begin
        r_instr <= r_imem[r_pc[AW+1:2]];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pc_err_nxt = r_pc_err;
    w_fetch      = 1'b0;
    unique case (r_state)
      IDLE, HALT: begin
        if (bus.start) begin
          w_state_nxt  = FETCH;
          w_pc_nxt     = PC_RESET;
          w_pc_err_nxt = 1'b0;
        end
      end
      FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (w_handshake) begin
          if (r_instr == HALT_WORD) begin
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt = w_npc;
            if (w_oor) begin
              w_state_nxt  = HALT;
              w_pc_err_nxt = 1'b1;
            end else begin
              w_state_nxt = FETCH;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.instr_valid = (r_state == ISSUE);
  assign bus.halted      = (r_state == HALT);
  assign bus.Instr       = r_instr;
  assign bus.pc          = r_pc;
  assign bus.pc_err      = r_pc_err;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, straight-line run, backpressure,
// branches, out-of-range halt, reset mid-issue and load/start interactions.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  instr_fetch_if #(.IMEM_DEPTH(64)) bus ();

  instr_fetch #(.IMEM_DEPTH(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    step();
    bus.load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic accept(input logic src);
    bus.PCSrc       = src;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    bus.PCSrc       = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    load_word(6'd0, 32'h1234_5678);
    reset = 1'b1; step(); step(); reset = 1'b0;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", bus.pc); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", bus.halted); end
    n_checks++; if (bus.pc_err !== 1'b0) begin n_fail++; $display("FAIL rst_pc_err got %b want 0", bus.pc_err); end
    n_checks++; if (bus.Instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", bus.Instr); end
    pulse_start();
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_valid got %b want 0", bus.instr_valid); end
    step();
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_issue_valid got %b want 1", bus.instr_valid); end
    n_checks++; if (bus.Instr !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_imem_kept got %h want 12345678", bus.Instr); end
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic test_straight();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h2001_0005; exp_i[1] = 32'h2002_0007; exp_i[2] = HALTW;
    for (int i = 0; i < 3; i++) load_word(6'(i), exp_i[i]);
    pulse_start();
    bus.PCSrc = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL sl_valid%0d got %b want 1", i, bus.instr_valid); end
      n_checks++; if (bus.Instr !== exp_i[i]) begin n_fail++; $display("FAIL sl_instr%0d got %h want %h", i, bus.Instr, exp_i[i]); end
      n_checks++; if (bus.pc !== 32'(i * 4)) begin n_fail++; $display("FAIL sl_pc%0d got %h want %h", i, bus.pc, 32'(i * 4)); end
      if (i == 2) bus.PCSrc = 1'b1;
      step();
      n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL sl_gap%0d got %b want 0", i, bus.instr_valid); end
    end
    bus.instr_ready = 1'b0;
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL sl_halted got %b want 1", bus.halted); end
    n_checks++; if (bus.pc !== 32'h8) begin n_fail++; $display("FAIL sl_halt_pc got %h want 8", bus.pc); end
    step(); step();
    n_checks++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL sl_halt_stay got h=%b v=%b want h=1 v=0", bus.halted, bus.instr_valid); end
    n_checks++; if (bus.Instr !== HALTW) begin n_fail++; $display("FAIL sl_instr_hold got %h want %h", bus.Instr, HALTW); end
  endtask

  task automatic test_backpressure();
    load_word(6'd0, 32'h2001_0005);
    load_word(6'd1, HALTW);
    pulse_start(); step();
    for (int i = 0; i < 5; i++) begin
      bus.PCSrc = 1'($urandom);
      step();
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.Instr !== 32'h2001_0005 || bus.pc !== 32'h0) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b i=%h pc=%h want v=1 i=20010005 pc=0", i, bus.instr_valid, bus.Instr, bus.pc);
      end
    end
    accept(1'b0);
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 32'h4) begin n_fail++; $display("FAIL bp_accept got v=%b pc=%h want v=0 pc=4", bus.instr_valid, bus.pc); end
    step();
    n_checks++; if (bus.Instr !== HALTW) begin n_fail++; $display("FAIL bp_next got %h want %h", bus.Instr, HALTW); end
    accept(1'b0);
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL bp_halt got %b want 1", bus.halted); end
  endtask

  task automatic test_branch();
    load_word(6'd0, 32'h2001_0005);
    load_word(6'd1, 32'h1000_0003);
    load_word(6'd5, 32'h1000_FFFA);
    load_word(6'd6, HALTW);
    pulse_start(); step();
    accept(1'b0);
    n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL br_notaken got %h want 4", bus.pc); end
    step();
    n_checks++; if (bus.Instr !== 32'h1000_0003) begin n_fail++; $display("FAIL br_instr1 got %h want 10000003", bus.Instr); end
    accept(1'b1);
    n_checks++; if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL br_fwd got %h want 14", bus.pc); end
    step();
    n_checks++; if (bus.Instr !== 32'h1000_FFFA) begin n_fail++; $display("FAIL br_instr5 got %h want 1000fffa", bus.Instr); end
    accept(1'b1);
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL br_back got %h want 0", bus.pc); end
    step();
    accept(1'b1);
    n_checks++; if (bus.pc !== 32'h18) begin n_fail++; $display("FAIL br_fwd2 got %h want 18", bus.pc); end
    step();
    n_checks++; if (bus.Instr !== HALTW || bus.pc !== 32'h18) begin n_fail++; $display("FAIL br_instr6 got %h pc=%h want %h pc=18", bus.Instr, bus.pc, HALTW); end
    accept(1'b0);
    n_checks++; if (bus.halted !== 1'b1 || bus.pc_err !== 1'b0) begin n_fail++; $display("FAIL br_halt got h=%b e=%b want h=1 e=0", bus.halted, bus.pc_err); end
  endtask

  task automatic test_out_of_range();
    load_word(6'd0, 32'h1000_003F);
    pulse_start(); step();
    accept(1'b1);
    n_checks++; if (bus.halted !== 1'b1 || bus.pc_err !== 1'b1 || bus.pc !== 32'h100) begin
      n_fail++; $display("FAIL oor_hi got h=%b e=%b pc=%h want h=1 e=1 pc=100", bus.halted, bus.pc_err, bus.pc);
    end
    pulse_start();
    n_checks++; if (bus.pc_err !== 1'b0 || bus.pc !== 32'h0 || bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL oor_restart got e=%b pc=%h h=%b want e=0 pc=0 h=0", bus.pc_err, bus.pc, bus.halted);
    end
    step();
    accept(1'b1);
    load_word(6'd0, 32'h1000_FFFE);
    pulse_start(); step();
    accept(1'b1);
    n_checks++; if (bus.pc_err !== 1'b1 || bus.pc !== 32'hFFFF_FFFC || bus.halted !== 1'b1) begin
      n_fail++; $display("FAIL oor_wrap got e=%b pc=%h h=%b want e=1 pc=fffffffc h=1", bus.pc_err, bus.pc, bus.halted);
    end
  endtask

  task automatic test_reset_mid();
    load_word(6'd0, 32'h2001_0005);
    load_word(6'd1, 32'h2002_0007);
    pulse_start(); step();
    bus.load_en = 1'b1; bus.load_addr = 6'd1; bus.load_data = 32'hDEAD_BEEF;
    step();
    bus.load_en = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== 32'h0 || bus.Instr !== 32'h0 || bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got v=%b pc=%h i=%h h=%b want v=0 pc=0 i=0 h=0", bus.instr_valid, bus.pc, bus.Instr, bus.halted);
    end
    pulse_start(); step();
    accept(1'b0);
    step();
    n_checks++; if (bus.Instr !== 32'h2002_0007) begin n_fail++; $display("FAIL mid_load_ignored got %h want 20020007", bus.Instr); end
    reset = 1'b1; step(); reset = 1'b0;
    bus.load_en = 1'b1; bus.load_addr = 6'd0; bus.load_data = 32'hCAFE_0001;
    bus.start = 1'b1;
    step();
    bus.load_en = 1'b0; bus.start = 1'b0;
    step();
    n_checks++; if (bus.Instr !== 32'hCAFE_0001 || bus.instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL wr_before_rd got %h v=%b want cafe0001 v=1", bus.Instr, bus.instr_valid);
    end
    pulse_start();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h0) begin
      n_fail++; $display("FAIL start_in_issue got v=%b pc=%h want v=1 pc=0", bus.instr_valid, bus.pc);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.load_en     = 1'b0;
    bus.load_addr   = '0;
    bus.load_data   = '0;
    bus.start       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.PCSrc       = 1'b0;
    test_reset();
    test_straight();
    test_backpressure();
    test_branch();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
